uart_rx_ctrl: RTL and testbench

Control and buffering front-end for the UART receiver. It holds the receiver's active frame configuration (parity, data bits, stop bits) and the 16x oversample divisor, and applies host configuration changes only while the receiver is idle. It also generates the 16x sample-enable tick and captures each completed frame, with its error flags, into a small first-word-fall-through (FWFT) FIFO for the host.

---
 rtl/uart_rx_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receiver control front-end: frame config shadowing, 16x tick, RX FIFO.
// Ports: i_cfg_* host config in; o_par/o_d_num/o_s_num/o_sample_tick to the
// receiver; i_rx_* receiver frame in; o_rd_* / o_fifo_count / o_overrun host.
module uart_rx_ctrl #(
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 26,
  parameter int DEPTH   = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_cfg_wr,
  input  logic [1:0]               i_cfg_par,
  input  logic                     i_cfg_d_num,
  input  logic                     i_cfg_s_num,
  input  logic [DIV_W-1:0]         i_cfg_div,
  output logic                     o_cfg_pending,
  output logic [1:0]               o_par,
  output logic                     o_d_num,
  output logic                     o_s_num,
  output logic                     o_sample_tick,
  input  logic                     i_rx_busy,
  input  logic                     i_rx_done,
  input  logic [7:0]               i_rx_dout,
  input  logic [2:0]               i_rx_err,
  input  logic                     i_rd_en,
  output logic [7:0]               o_rd_data,
  output logic [2:0]               o_rd_err,
  output logic                     o_rd_valid,
  output logic [$clog2(DEPTH):0]   o_fifo_count,
  output logic                     o_overrun,
  input  logic                     i_ovr_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_APPLY
  } state_t;

  state_t           r_state;
  logic             r_pending;
  logic [1:0]       r_par;
  logic             r_d_num;
  logic             r_s_num;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_sh_par;
  logic             r_sh_d_num;
  logic             r_sh_s_num;
  logic [DIV_W-1:0] r_sh_div;
  logic [DIV_W-1:0] r_cnt;

  logic             w_apply;
  logic             w_tick;

  // Config FSM: host writes land in the shadow and only reach the
  // receiver in the single APPLY cycle, when no frame is in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_pending  <= 1'b0;
      r_par      <= 2'b00;
      r_d_num    <= 1'b1;
      r_s_num    <= 1'b0;
      r_div      <= DIV_W'(DEF_DIV);
      r_sh_par   <= 2'b00;
      r_sh_d_num <= 1'b1;
      r_sh_s_num <= 1'b0;
      r_sh_div   <= DIV_W'(DEF_DIV);
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_cfg_wr) begin
            r_sh_par   <= i_cfg_par;
            r_sh_d_num <= i_cfg_d_num;
            r_sh_s_num <= i_cfg_s_num;
            r_sh_div   <= i_cfg_div;
            r_pending  <= 1'b1;
            r_state    <= S_PEND;
          end
        end
        S_PEND: begin
          if (i_cfg_wr) begin
            r_sh_par   <= i_cfg_par;
            r_sh_d_num <= i_cfg_d_num;
            r_sh_s_num <= i_cfg_s_num;
            r_sh_div   <= i_cfg_div;
          end else if (!i_rx_busy && !i_rx_done) begin
            r_state <= S_APPLY;
          end
        end
        S_APPLY: begin
          r_par   <= r_sh_par;
          r_d_num <= r_sh_d_num;
          r_s_num <= r_sh_s_num;
          r_div   <= r_sh_div;
          if (i_cfg_wr) begin
            r_sh_par   <= i_cfg_par;
            r_sh_d_num <= i_cfg_d_num;
            r_sh_s_num <= i_cfg_s_num;
            r_sh_div   <= i_cfg_div;
            r_state    <= S_PEND;
          end else begin
            r_pending <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_pending <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign w_apply = (r_state == S_APPLY);

  // Restarting the count on APPLY keeps a shrinking divisor from
  // leaving the counter stranded above the new terminal value.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (w_apply) begin
      r_cnt <= '0;
    end else if (r_cnt == r_div) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

  assign w_tick = (r_cnt == r_div) && !w_apply;

  assign o_cfg_pending = r_pending;
  assign o_par         = r_par;
  assign o_d_num       = r_d_num;
  assign o_s_num       = r_s_num;
  assign o_sample_tick = w_tick;

  logic [10:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overrun;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic [10:0]   w_head;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = i_rd_en && !w_empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign w_push  = i_rx_done && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {i_rx_err, i_rx_dout};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Set has priority so a drop in the clearing cycle is not lost.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_overrun <= 1'b0;
    end else if (i_rx_done && w_full && !w_pop) begin
      r_overrun <= 1'b1;
    end else if (i_ovr_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign w_head       = r_mem[r_rptr];
  assign o_rd_data    = w_empty ? 8'h00 : w_head[7:0];
  assign o_rd_err     = w_empty ? 3'b000 : w_head[10:8];
  assign o_rd_valid   = !w_empty;
  assign o_fifo_count = r_count;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed config, tick and FIFO vectors.
// FIFO reads are checked by a monitor popping an expected-value queue.
module tb_uart_rx_ctrl;

  logic        clk;
  logic        reset;
  logic        cfg_wr;
  logic [1:0]  cfg_par;
  logic        cfg_d_num;
  logic        cfg_s_num;
  logic [15:0] cfg_div;
  logic        cfg_pending;
  logic [1:0]  par;
  logic        d_num;
  logic        s_num;
  logic        sample_tick;
  logic        rx_busy;
  logic        rx_done;
  logic [7:0]  rx_dout;
  logic [2:0]  rx_err;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic [2:0]  rd_err;
  logic        rd_valid;
  logic [2:0]  fifo_count;
  logic        overrun;
  logic        ovr_clr;

  int          n_vec;
  int          n_err;
  int          mcount;
  logic [10:0] exp_q [$];
  logic [10:0] mon_e;

  uart_rx_ctrl dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_cfg_wr      (cfg_wr),
    .i_cfg_par     (cfg_par),
    .i_cfg_d_num   (cfg_d_num),
    .i_cfg_s_num   (cfg_s_num),
    .i_cfg_div     (cfg_div),
    .o_cfg_pending (cfg_pending),
    .o_par         (par),
    .o_d_num       (d_num),
    .o_s_num       (s_num),
    .o_sample_tick (sample_tick),
    .i_rx_busy     (rx_busy),
    .i_rx_done     (rx_done),
    .i_rx_dout     (rx_dout),
    .i_rx_err      (rx_err),
    .i_rd_en       (rd_en),
    .o_rd_data     (rd_data),
    .o_rd_err      (rd_err),
    .o_rd_valid    (rd_valid),
    .o_fifo_count  (fifo_count),
    .o_overrun     (overrun),
    .i_ovr_clr     (ovr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // One cycle of receiver/host activity; the queue is fed in order.
  task automatic drive(input logic done, input logic [7:0] d,
                       input logic [2:0] e, input logic rd);
    logic pop;
    logic acc;
    rx_done = done;
    rx_dout = d;
    rx_err  = e;
    rd_en   = rd;
    pop = rd && (mcount > 0);
    acc = done && ((mcount < 4) || pop);
    if (acc) exp_q.push_back({e, d});
    mcount = mcount + int'(acc) - int'(pop);
    nxt();
    rx_done = 1'b0;
    rx_dout = 8'h00;
    rx_err  = 3'b000;
    rd_en   = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && rd_en && rd_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pop_extra: got %0h/%0h want none", rd_err, rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rd_err, rd_data} !== mon_e) begin
          n_err++;
          $display("FAIL pop_data: got %0h want %0h",
                   {rd_err, rd_data}, mon_e);
        end
      end
    end
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    mcount    = 0;
    reset     = 1'b1;
    cfg_wr    = 1'b0;
    cfg_par   = 2'b00;
    cfg_d_num = 1'b0;
    cfg_s_num = 1'b0;
    cfg_div   = 16'd0;
    rx_busy   = 1'b0;
    rx_done   = 1'b0;
    rx_dout   = 8'h00;
    rx_err    = 3'b000;
    rd_en     = 1'b0;
    ovr_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state and default tick period of 27 clocks
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("rst_par", par, 2'b00);
        chk("rst_d_num", d_num, 1'b1);
        chk("rst_s_num", s_num, 1'b0);
        chk("rst_valid", rd_valid, 1'b0);
        chk("rst_count", fifo_count, 3'd0);
        chk("rst_pend", cfg_pending, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        chk("rst_rdata", rd_data, 8'h00);
        chk("rst_rerr", rd_err, 3'b000);
      end
      chk("tick_def", sample_tick, (k % 27) == 26);
      nxt();
    end

    // config held while busy, applied 2 clocks after busy drops
    rx_busy   = 1'b1;
    cfg_wr    = 1'b1;
    cfg_par   = 2'b01;
    cfg_d_num = 1'b0;
    cfg_s_num = 1'b1;
    cfg_div   = 16'd3;
    nxt();
    cfg_wr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("busy_pend", cfg_pending, 1'b1);
      chk("busy_par", par, 2'b00);
      chk("busy_d", d_num, 1'b1);
      chk("busy_s", s_num, 1'b0);
      nxt();
    end
    rx_busy = 1'b0;
    @(negedge clk);
    chk("drop_pend", cfg_pending, 1'b1);
    nxt();
    @(negedge clk);
    chk("apply_pend", cfg_pending, 1'b1);
    chk("apply_par", par, 2'b00);
    chk("apply_tick", sample_tick, 1'b0);
    nxt();
    @(negedge clk);
    chk("new_par", par, 2'b01);
    chk("new_d", d_num, 1'b0);
    chk("new_s", s_num, 1'b1);
    chk("new_pend", cfg_pending, 1'b0);
    for (int j = 0; j < 12; j++) begin
      if (j > 0) @(negedge clk);
      chk("tick_div3", sample_tick, (j % 4) == 3);
      nxt();
    end

    // last write wins while pending
    rx_busy   = 1'b1;
    cfg_wr    = 1'b1;
    cfg_par   = 2'b11;
    cfg_d_num = 1'b1;
    cfg_s_num = 1'b0;
    cfg_div   = 16'd5;
    nxt();
    cfg_par   = 2'b10;
    cfg_d_num = 1'b0;
    cfg_s_num = 1'b1;
    cfg_div   = 16'd7;
    nxt();
    cfg_wr  = 1'b0;
    rx_busy = 1'b0;
    @(negedge clk);
    chk("ovw_pend", cfg_pending, 1'b1);
    chk("ovw_par_old", par, 2'b01);
    nxt();
    @(negedge clk);
    chk("ovw_apply_par", par, 2'b01);
    nxt();
    @(negedge clk);
    chk("ovw_par", par, 2'b10);
    chk("ovw_d", d_num, 1'b0);
    chk("ovw_s", s_num, 1'b1);
    for (int j = 0; j < 16; j++) begin
      if (j > 0) @(negedge clk);
      chk("tick_div7", sample_tick, (j % 8) == 7);
      nxt();
    end

    // FIFO ordering, error flags kept
    drive(1'b1, 8'h41, 3'b000, 1'b0);
    drive(1'b1, 8'h42, 3'b000, 1'b0);
    drive(1'b1, 8'h43, 3'b100, 1'b0);
    @(negedge clk);
    chk("f3_count", fifo_count, 3'd3);
    chk("f3_valid", rd_valid, 1'b1);
    chk("f3_head", rd_data, 8'h41);
    nxt();
    repeat (3) drive(1'b0, 8'h00, 3'b000, 1'b1);
    @(negedge clk);
    chk("f3_empty", rd_valid, 1'b0);
    chk("f3_cnt0", fifo_count, 3'd0);
    chk("f3_rdata0", rd_data, 8'h00);
    nxt();

    // push and pop together when empty: push only
    drive(1'b1, 8'h55, 3'b010, 1'b1);
    @(negedge clk);
    chk("pe_count", fifo_count, 3'd1);
    chk("pe_head", rd_data, 8'h55);
    chk("pe_err", rd_err, 3'b010);
    nxt();
    drive(1'b0, 8'h00, 3'b000, 1'b1);

    // overrun on 5th frame, full push+pop, clear priority
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h10 + 8'(i), 3'b000, 1'b0);
    @(negedge clk);
    chk("ov_count", fifo_count, 3'd4);
    chk("ov_set", overrun, 1'b1);
    nxt();
    drive(1'b1, 8'h20, 3'b001, 1'b1);
    @(negedge clk);
    chk("fp_count", fifo_count, 3'd4);
    chk("fp_ovr", overrun, 1'b1);
    chk("fp_head", rd_data, 8'h11);
    nxt();
    ovr_clr = 1'b1;
    nxt();
    ovr_clr = 1'b0;
    @(negedge clk);
    chk("ov_clr", overrun, 1'b0);
    nxt();
    ovr_clr = 1'b1;
    drive(1'b1, 8'h21, 3'b000, 1'b0);
    ovr_clr = 1'b0;
    @(negedge clk);
    chk("ov_setwins", overrun, 1'b1);
    chk("ov_cnt4", fifo_count, 3'd4);
    nxt();
    ovr_clr = 1'b1;
    nxt();
    ovr_clr = 1'b0;
    repeat (4) drive(1'b0, 8'h00, 3'b000, 1'b1);
    @(negedge clk);
    chk("ov_clr2", overrun, 1'b0);
    chk("ov_drained", rd_valid, 1'b0);
    chk("sb_empty", exp_q.size(), 0);
    nxt();

    // reset with entries queued and config pending
    drive(1'b1, 8'h77, 3'b000, 1'b0);
    drive(1'b1, 8'h78, 3'b000, 1'b0);
    rx_busy   = 1'b1;
    cfg_wr    = 1'b1;
    cfg_par   = 2'b01;
    cfg_d_num = 1'b1;
    cfg_s_num = 1'b0;
    cfg_div   = 16'd9;
    nxt();
    cfg_wr = 1'b0;
    @(negedge clk);
    chk("pr_pend", cfg_pending, 1'b1);
    chk("pr_count", fifo_count, 3'd2);
    nxt();
    reset   = 1'b1;
    rx_done = 1'b1;
    rx_dout = 8'h99;
    nxt();
    reset   = 1'b0;
    rx_done = 1'b0;
    rx_dout = 8'h00;
    rx_busy = 1'b0;
    exp_q.delete();
    mcount = 0;
    @(negedge clk);
    chk("rr_count", fifo_count, 3'd0);
    chk("rr_pend", cfg_pending, 1'b0);
    chk("rr_par", par, 2'b00);
    chk("rr_d", d_num, 1'b1);
    chk("rr_s", s_num, 1'b0);
    chk("rr_valid", rd_valid, 1'b0);
    chk("rr_tick0", sample_tick, 1'b0);
    nxt();
    for (int k = 1; k < 28; k++) begin
      @(negedge clk);
      chk("rr_tick", sample_tick, k == 26);
      nxt();
    end
    @(negedge clk);
    chk("rr_lost", fifo_count, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
